// File: rtl/traffic_dp.sv
// Phase timer and lamp register stage for the traffic-light controller.
// Times each light phase, flags completion to ctrl, and registers the lamp outputs.
module traffic_dp #(
  parameter int CNT_W = 11,
  parameter int T_G1  = 1024,
  parameter int T_N1  = 16,
  parameter int T_G2  = 16,
  parameter int T_N2  = 16,
  parameter int T_G3  = 16,
  parameter int T_Y   = 512,
  parameter int T_R   = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] curr_state,
  input  logic       dp_cnt_rst,
  output logic [6:0] done_state,
  output logic       light_g,
  output logic       light_y,
  output logic       light_r
);

  localparam logic [CNT_W-1:0] LIM_G1 = CNT_W'(T_G1 - 1);
  localparam logic [CNT_W-1:0] LIM_N1 = CNT_W'(T_N1 - 1);
  localparam logic [CNT_W-1:0] LIM_G2 = CNT_W'(T_G2 - 1);
  localparam logic [CNT_W-1:0] LIM_N2 = CNT_W'(T_N2 - 1);
  localparam logic [CNT_W-1:0] LIM_G3 = CNT_W'(T_G3 - 1);
  localparam logic [CNT_W-1:0] LIM_Y  = CNT_W'(T_Y - 1);
  localparam logic [CNT_W-1:0] LIM_R  = CNT_W'(T_R - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       gph_q, gph_d;
  logic [2:0]       lamp_q, lamp_d;
  logic             st_legal;
  logic             s_g, s_y, s_r, s_none;
  logic [6:0]       done;

  // Legal only when exactly one state bit is set.
  assign st_legal = (curr_state != 4'b0000) &&
                    ((curr_state & (curr_state - 4'd1)) == 4'b0000);
  assign s_g    = st_legal & curr_state[0];
  assign s_y    = st_legal & curr_state[1];
  assign s_r    = st_legal & curr_state[2];
  assign s_none = st_legal & curr_state[3];

  always_comb begin
    done = '0;
    // Done flags are held low while the block is in reset.
    if (rst) begin
      done[0] = s_g    && (gph_q == 2'd0) && (cnt_q == LIM_G1);
      done[1] = s_g    && (gph_q == 2'd1) && (cnt_q == LIM_G2);
      done[2] = s_g    && (gph_q == 2'd2) && (cnt_q == LIM_G3);
      done[3] = s_y    && (cnt_q == LIM_Y);
      done[4] = s_r    && (cnt_q == LIM_R);
      done[5] = s_none && (gph_q == 2'd1) && (cnt_q == LIM_N1);
      done[6] = s_none && (gph_q == 2'd2) && (cnt_q == LIM_N2);
    end
  end

  assign done_state = done;

  always_comb begin
    cnt_d = cnt_q;
    if (dp_cnt_rst || !st_legal) begin
      cnt_d = '0;
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_comb begin
    gph_d = gph_q;
    if (gph_q == 2'd3) begin
      gph_d = 2'd0;
    end else if (done[0]) begin
      gph_d = 2'd1;
    end else if (done[1]) begin
      gph_d = 2'd2;
    end else if (done[2]) begin
      gph_d = 2'd0;
    end
  end

  always_comb begin
    lamp_d = {s_r, s_y, s_g};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      gph_q  <= '0;
      lamp_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      gph_q  <= gph_d;
      lamp_q <= lamp_d;
    end
  end

  assign light_g = lamp_q[0];
  assign light_y = lamp_q[1];
  assign light_r = lamp_q[2];

endmodule

// File: tb/tb_traffic_dp.sv
// Scoreboard bench for traffic_dp: directed phase sequences push per-cycle
// expected done/lamp values, a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_traffic_dp;

  localparam logic [3:0] S_G = 4'b0001, S_Y = 4'b0010, S_R = 4'b0100, S_N = 4'b1000;

  typedef struct {
    int         cyc;
    logic [6:0] val;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] cs = S_G, cs1 = S_G;
  logic       crst = 1'b1, crst1 = 1'b1;
  logic [6:0] done_state, done1;
  logic       light_g, light_y, light_r;
  logic       l1_g, l1_y, l1_r;

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t done_q[$], done1_q[$], lamp_q[$];

  logic       prev_rst = 1'b0;
  logic [3:0] prev_cs  = 4'b0000;
  logic [6:0] exp1     = 7'h00;
  logic       t1_run   = 1'b0;

  logic [3:0] t1_st  [7] = '{S_G, S_N, S_G, S_N, S_G, S_Y, S_R};
  logic [6:0] t1_exp [7] = '{7'h01, 7'h20, 7'h02, 7'h40, 7'h04, 7'h08, 7'h10};

  traffic_dp u_dut (
    .clk(clk), .rst(rst), .curr_state(cs), .dp_cnt_rst(crst),
    .done_state(done_state), .light_g(light_g), .light_y(light_y), .light_r(light_r)
  );

  traffic_dp #(
    .CNT_W(1), .T_G1(1), .T_N1(1), .T_G2(1), .T_N2(1), .T_G3(1), .T_Y(1), .T_R(1)
  ) u_dut1 (
    .clk(clk), .rst(rst), .curr_state(cs1), .dp_cnt_rst(crst1),
    .done_state(done1), .light_g(l1_g), .light_y(l1_y), .light_r(l1_r)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [2:0] lamp_of(input logic [3:0] s);
    if ($countones(s) == 1) return s[2:0];
    return 3'b000;
  endfunction

  // One clock cycle of stimulus; expected values for this cycle go to the queues.
  task automatic drive(input logic r, input logic [3:0] st, input logic cr, input logic [6:0] ed);
    exp_t e;
    rst  = r;
    cs   = st;
    crst = cr;
    e.cyc = cyc;
    e.val = {4'b0000, (r && prev_rst) ? lamp_of(prev_cs) : 3'b000};
    lamp_q.push_back(e);
    e.val = ed;
    done_q.push_back(e);
    e.val = exp1;
    done1_q.push_back(e);
    prev_rst = r;
    prev_cs  = st;
    @(posedge clk);
    #1;
  endtask

  task automatic phase(input logic [3:0] st, input int len, input logic [6:0] dval, input logic cr_last);
    for (int i = 0; i < len; i++) begin
      if (t1_run && i < 7) begin
        cs1 = t1_st[i]; crst1 = 1'b1; exp1 = t1_exp[i];
      end else begin
        cs1 = 4'b0000; crst1 = 1'b0; exp1 = 7'h00;
      end
      drive(1'b1, st, (i == len - 1) && cr_last, (i == len - 1) ? dval : 7'h00);
    end
  endtask

  task automatic do_reset(input int n, input logic [3:0] st);
    for (int i = 0; i < n; i++) begin
      cs1 = S_G; crst1 = 1'b0; exp1 = 7'h00;
      drive(1'b0, st, 1'b0, 7'h00);
    end
  endtask

  task automatic check_q(inout exp_t q[$], input logic [6:0] act, input string name);
    exp_t e;
    while (q.size() > 0 && q[0].cyc < cyc) begin
      e = q.pop_front();
      n_cmp++; n_bad++;
      $display("FAIL %s cyc=%0d expected entry never compared exp=%h", name, e.cyc, e.val);
    end
    if (q.size() > 0 && q[0].cyc == cyc) begin
      e = q.pop_front();
      n_cmp++;
      if (act !== e.val) begin
        n_bad++;
        $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, act, e.val);
      end
    end else if (act != 7'h00) begin
      n_cmp++; n_bad++;
      $display("FAIL %s cyc=%0d unexpected got=%h exp=00", name, cyc, act);
    end
  endtask

  always @(negedge clk) begin
    check_q(done_q,  done_state, "done");
    check_q(done1_q, done1, "done_t1");
    check_q(lamp_q,  {4'b0000, light_r, light_y, light_g}, "lamps");
  end

  initial begin
    @(posedge clk);
    #1;
    do_reset(3, S_G);

    // Full default cycle; the T=1 instance runs its whole sequence alongside.
    t1_run = 1'b1;
    phase(S_G, 1024, 7'h01, 1'b1);
    t1_run = 1'b0;
    phase(S_N, 16,   7'h20, 1'b1);
    phase(S_G, 16,   7'h02, 1'b1);
    phase(S_N, 16,   7'h40, 1'b1);
    phase(S_G, 16,   7'h04, 1'b1);
    phase(S_Y, 512,  7'h08, 1'b1);
    phase(S_R, 1024, 7'h10, 1'b1);
    phase(S_G, 1024, 7'h01, 1'b1);

    // Reset in the middle of yellow restarts at G1.
    phase(S_N, 16, 7'h20, 1'b1);
    phase(S_G, 16, 7'h02, 1'b1);
    phase(S_N, 16, 7'h40, 1'b1);
    phase(S_G, 16, 7'h04, 1'b1);
    phase(S_Y, 200, 7'h00, 1'b0);
    do_reset(3, S_Y);
    phase(S_G, 1024, 7'h01, 1'b1);

    // Illegal states clear the counter and raise nothing.
    do_reset(2, S_G);
    phase(S_G, 500, 7'h00, 1'b0);
    phase(4'b0000, 5, 7'h00, 1'b0);
    phase(4'b0101, 5, 7'h00, 1'b0);
    phase(S_G, 1024, 7'h01, 1'b1);

    // Spurious counter clear mid G1 leaves gph at 0.
    do_reset(2, S_G);
    phase(S_G, 500, 7'h00, 1'b0);
    drive(1'b1, S_G, 1'b1, 7'h00);
    phase(S_G, 1024, 7'h01, 1'b1);

    // NONE with gph=0 never completes; saturation then single-cycle done.
    do_reset(2, S_G);
    phase(S_N, 2100, 7'h00, 1'b0);
    phase(S_G, 3, 7'h00, 1'b0);
    drive(1'b1, S_G, 1'b1, 7'h00);
    phase(S_G, 1024, 7'h01, 1'b0);
    phase(S_G, 3, 7'h00, 1'b0);

    phase(4'b0000, 2, 7'h00, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/traffic_dp.md
# traffic_dp

Datapath stage paired with the traffic-light controller `ctrl`. It times every light phase and reports phase completion to `ctrl` on `done_state`. It consumes `ctrl`'s one-hot `curr_state` and `dp_cnt_rst`, and drives registered lamp outputs. The green sequence is Long-green, Off, Short-green, Off, Short-green, then Yellow and Red. `ctrl` sees this as states G/NONE plus the sub-indexed done flags G1/G2/G3 and NONE1/NONE2.

## Interface
- `CNT_W`, 11: phase counter width; must hold max(T_*) − 1.
- `T_G1`, 1024: first (long) green length, cycles.
- `T_N1`, 16: first dark gap length.
- `T_G2`, 16: second green length.
- `T_N2`, 16: second dark gap length.
- `T_G3`, 16: third green length.
- `T_Y`, 512: yellow length.
- `T_R`, 1024: red length.
- Constraint: every T_* must be ≥ 1.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `curr_state`  in  4  one-hot state from `ctrl`: [0]=S_G, [1]=S_Y, [2]=S_R, [3]=S_NONE.
- `dp_cnt_rst`  in  1  synchronous counter clear from `ctrl`.
- `done_state`  out  7  combinational phase-done flags: [0]=DONE_G1, [1]=DONE_G2, [2]=DONE_G3, [3]=DONE_Y, [4]=DONE_R, [5]=DONE_NONE1, [6]=DONE_NONE2.
- `light_g`  out  1  green lamp, registered.
- `light_y`  out  1  yellow lamp, registered.
- `light_r`  out  1  red lamp, registered.

## Operation
- **`cnt` (CNT_W-bit phase counter)**
  - Priority on each edge: `dp_cnt_rst`=1 → 0; else illegal `curr_state` → 0; else +1, saturating at all-ones.
  - `curr_state` is illegal when it is zero or has more than one bit set.
- **`gph` (2-bit green sub-phase register)**
  - Reset value 0.
  - Updated on the edge where a done flag is high:
    - DONE_G1 → 1.
    - DONE_G2 → 2.
    - DONE_G3 → 0.
  - NONE-done flags do not change `gph`.
  - Value 3 is illegal. It produces no G or NONE done flags and recovers to 0 on the next edge.
- **Done decode** (each flag also requires the listed state bit and `cnt == T−1`):
  - DONE_G1: S_G and `gph`=0, T_G1.
  - DONE_G2: S_G and `gph`=1, T_G2.
  - DONE_G3: S_G and `gph`=2, T_G3.
  - DONE_NONE1: S_NONE and `gph`=1, T_N1.
  - DONE_NONE2: S_NONE and `gph`=2, T_N2.
  - DONE_Y: S_Y, T_Y.
  - DONE_R: S_R, T_R.
  - Illegal state or S_NONE with `gph`=0: all flags 0.
  - At most one bit of `done_state` is high in any cycle.
- **Lamps**
  - Registered from `curr_state` each edge: `light_g`=S_G, `light_y`=S_Y, `light_r`=S_R.
  - S_NONE and illegal states → all lamps 0.

## Timing
- **Reset values:** `cnt`=0, `gph`=0, all lamps 0. `done_state` is 0 while reset is asserted (outputs forced low).
- **Phase length:** `cnt`=0 on the first cycle of a phase, so done rises on that phase's cycle T. `ctrl` asserts `dp_cnt_rst` in the same cycle and changes state on the next edge, so each phase occupies exactly T cycles.
- **T=1:** done is high on the first cycle of the phase.
- **`dp_cnt_rst` without done** (e.g. `ctrl` in reset): counter clears; `gph` is unaffected.
- **Reset mid-phase:** async clear of `cnt`, `gph` and lamps. The sequence restarts at G1.
- **Saturation:** if `ctrl` never acts on done, `cnt` holds at all-ones. Done stays high only while `cnt == T−1`, so it is a single-cycle pulse in that case.
- **Lamp latency:** lamps lag `curr_state` by 1 cycle.
- **`done_state` latency:** 0 cycles from `cnt`/`curr_state`/`gph`; no registers on this path.

## Test plan
- **Full cycle, defaults, with `ctrl`:** release reset → G 1024, NONE 16, G 16, NONE 16, G 16, Y 512, R 1024 cycles, then G1 again with `gph`=0. Each done bit pulses once, in order G1, NONE1, G2, NONE2, G3, Y, R.
- **Lamp check during full cycle:** `light_g` high for 1024+16+16 cycles, each segment delayed 1 cycle from the state. Lamps are all 0 during both NONE gaps. `light_y` is high 512 cycles and `light_r` 1024 cycles.
- **T_*=1 build:** every phase lasts 1 cycle; the full sequence completes in 7 cycles after the first G.
- **Reset mid-yellow:** drop `rst` at Y cycle 200 → lamps 0 and `cnt`=0 immediately. After release, the next G1 done comes 1024 cycles after G entry.
- **Illegal `curr_state`:** drive 4'b0000 or 4'b0101 for 5 cycles → `done_state`=0, `cnt`=0, lamps 0. Driving S_NONE with `gph`=0 gives no done, and `cnt` saturates at 2047.
- **Spurious `dp_cnt_rst`:** pulse at G1 cycle 500 → `cnt` restarts from 0. DONE_G1 then arrives 1024 cycles after the pulse, and `gph` stays 0 until then.
